// File: rtl/e_clock_vpa.sv
// 68000-style E clock generator and VPA/VMA synchronous-peripheral handshake.
// Returns an active-low EDTACK to the bus translator once the cycle is aligned to E.
module e_clock_vpa #(
    parameter int unsigned E_LOW  = 6,
    parameter int unsigned E_HIGH = 4,
    parameter int unsigned VMA_AT = 3
) (
    input  logic       CLK7M,
    input  logic       RESET,
    input  logic       AS,
    input  logic       VPA,
    output logic       E,
    output logic       VMA,
    output logic       EDTACK,
    output logic [3:0] ECNT
);

    localparam int unsigned P = E_LOW + E_HIGH;
    localparam logic [3:0] CntMax   = 4'(P - 1);
    localparam logic [3:0] CntAck   = 4'(P - 2);
    localparam logic [3:0] CntSync  = 4'(VMA_AT - 1);
    localparam logic [3:0] CntERise = 4'(E_LOW);

    typedef enum logic [1:0] {StIdle, StWaitSync, StVmaOn, StDone} state_t;

    state_t     r_state;
    logic [3:0] r_ecnt;
    logic       r_e;
    logic       r_vma;
    logic       r_edtack;
    logic [3:0] w_ecnt_nxt;

    assign w_ecnt_nxt = (r_ecnt == CntMax) ? 4'd0 : r_ecnt + 4'd1;

    // E is derived from the next count so it changes on the same edge as ECNT.
    always_ff @(posedge CLK7M or negedge RESET) begin
        if (!RESET) begin
            r_ecnt <= 4'd0;
            r_e    <= 1'b0;
        end else begin
            r_ecnt <= w_ecnt_nxt;
            r_e    <= (w_ecnt_nxt >= CntERise);
        end
    end

    always_ff @(posedge CLK7M or negedge RESET) begin
        if (!RESET) begin
            r_state  <= StIdle;
            r_vma    <= 1'b1;
            r_edtack <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_vma    <= 1'b1;
                    r_edtack <= 1'b1;
                    if (!AS && !VPA) begin
                        r_state <= StWaitSync;
                    end
                end
                StWaitSync: begin
                    if (AS) begin
                        r_state <= StIdle;
                    end else if (r_ecnt == CntSync) begin
                        r_state <= StVmaOn;
                        r_vma   <= 1'b0;
                    end
                end
                StVmaOn: begin
                    // An abort always wins over a scheduled EDTACK assertion.
                    if (AS) begin
                        r_state  <= StIdle;
                        r_vma    <= 1'b1;
                        r_edtack <= 1'b1;
                    end else if (r_ecnt == CntAck) begin
                        r_edtack <= 1'b0;
                    end else if (r_ecnt == CntMax) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (AS) begin
                        r_state  <= StIdle;
                        r_vma    <= 1'b1;
                        r_edtack <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_vma    <= 1'b1;
                    r_edtack <= 1'b1;
                end
            endcase
        end
    end

    assign ECNT   = r_ecnt;
    assign E      = r_e;
    assign VMA    = r_vma;
    assign EDTACK = r_edtack;

endmodule

// File: tb/tb_e_clock_vpa.sv
// Directed bench for e_clock_vpa: free-running E, aligned/late/aborted requests,
// asynchronous mid-cycle reset and AS without VPA.
module tb_e_clock_vpa;

    logic       CLK7M;
    logic       RESET;
    logic       AS;
    logic       VPA;
    logic       E;
    logic       VMA;
    logic       EDTACK;
    logic [3:0] ECNT;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;

    e_clock_vpa #(
        .E_LOW  (6),
        .E_HIGH (4),
        .VMA_AT (3)
    ) dut (
        .CLK7M  (CLK7M),
        .RESET  (RESET),
        .AS     (AS),
        .VPA    (VPA),
        .E      (E),
        .VMA    (VMA),
        .EDTACK (EDTACK),
        .ECNT   (ECNT)
    );

    initial CLK7M = 1'b0;
    always #5 CLK7M = ~CLK7M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge, then compare everything against the bench's own counter model.
    task automatic step(input string tag, input logic exp_vma, input logic exp_edtack);
        @(posedge CLK7M);
        #1;
        m_cnt = (m_cnt + 1) % 10;
        check({tag, ".ecnt"}, 32'(ECNT), 32'(m_cnt));
        check({tag, ".e"}, 32'(E), (m_cnt >= 6) ? 32'd1 : 32'd0);
        check({tag, ".vma"}, 32'(VMA), 32'(exp_vma));
        check({tag, ".edtack"}, 32'(EDTACK), 32'(exp_edtack));
    endtask

    task automatic steps(input string tag, input int n, input logic exp_vma,
                         input logic exp_edtack);
        for (int i = 0; i < n; i++) step(tag, exp_vma, exp_edtack);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        AS    = 1'b1;
        VPA   = 1'b1;
        repeat (3) @(posedge CLK7M);
        #1;
        check("rst.e", 32'(E), 32'd0);
        check("rst.vma", 32'(VMA), 32'd1);
        check("rst.edtack", 32'(EDTACK), 32'd1);
        check("rst.ecnt", 32'(ECNT), 32'd0);

        // Free run: E rises at edge 6, falls at 10, rises at 16.
        @(negedge CLK7M);
        RESET = 1'b1;
        m_cnt = 0;
        steps("free", 20, 1'b1, 1'b1);

        // Aligned request sampled at ECNT=0.
        AS  = 1'b0;
        VPA = 1'b0;
        steps("algn.wait", 2, 1'b1, 1'b1);
        steps("algn.vma", 6, 1'b0, 1'b1);
        steps("algn.ack", 2, 1'b0, 1'b0);
        VPA = 1'b1;
        steps("algn.done", 1, 1'b0, 1'b0);
        AS = 1'b1;
        steps("algn.rel", 1, 1'b1, 1'b1);

        // Late request sampled at ECNT=5; VPA negating afterwards is ignored.
        steps("late.idle", 3, 1'b1, 1'b1);
        AS  = 1'b0;
        VPA = 1'b0;
        steps("late.wait0", 1, 1'b1, 1'b1);
        VPA = 1'b1;
        steps("late.wait", 6, 1'b1, 1'b1);
        steps("late.vma", 6, 1'b0, 1'b1);
        steps("late.ack", 2, 1'b0, 1'b0);
        AS = 1'b1;
        steps("late.rel", 1, 1'b1, 1'b1);

        // Abort in WAIT_SYNC at ECNT=8, then a fresh aligned request.
        steps("abrt.idle", 4, 1'b1, 1'b1);
        AS  = 1'b0;
        VPA = 1'b0;
        steps("abrt.wait", 3, 1'b1, 1'b1);
        AS  = 1'b1;
        VPA = 1'b1;
        steps("abrt.idle2", 2, 1'b1, 1'b1);
        AS  = 1'b0;
        VPA = 1'b0;
        steps("abrt.new", 2, 1'b1, 1'b1);
        steps("abrt.vma", 5, 1'b0, 1'b1);

        // Asynchronous reset while in VMA_ON at ECNT=7, between clock edges.
        #2;
        RESET = 1'b0;
        #1;
        check("arst.e", 32'(E), 32'd0);
        check("arst.ecnt", 32'(ECNT), 32'd0);
        check("arst.vma", 32'(VMA), 32'd1);
        check("arst.edtack", 32'(EDTACK), 32'd1);
        AS  = 1'b1;
        VPA = 1'b1;
        repeat (2) @(posedge CLK7M);
        @(negedge CLK7M);
        RESET = 1'b1;
        m_cnt = 0;

        // AS without VPA never starts a handshake.
        AS  = 1'b0;
        VPA = 1'b1;
        steps("novpa", 30, 1'b1, 1'b1);
        AS = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
